// File: rtl/complex_dot_pkg.sv
// complex_dot_pkg: shared FSM states, pipeline depth and complex-field helpers for the streaming dot product.
package complex_dot_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int PIPE_LAT   = 3;
    localparam int MAX_ELEM_W = 128;

    // Callers narrow the result to ELEM_W/2 bits.
    function automatic logic [MAX_ELEM_W-1:0] cplx_re(input logic [MAX_ELEM_W-1:0] e, input int elem_w);
        return e >> (elem_w / 2);
    endfunction

    function automatic logic [MAX_ELEM_W-1:0] cplx_im(input logic [MAX_ELEM_W-1:0] e, input int elem_w);
        return e & ({MAX_ELEM_W{1'b1}} >> (MAX_ELEM_W - elem_w / 2));
    endfunction

    function automatic logic [31:0] nbeats(input logic [31:0] total, input int lanes);
        logic [32:0] t;
        t = {1'b0, total} + 33'(lanes - 1);
        return 32'(t / 33'(lanes));
    endfunction

endpackage

// File: rtl/complex_mac_lane.sv
// complex_mac_lane: one registered complex multiply, optionally conjugating B.
// Disabled lanes multiply zeros so masked elements contribute nothing.
module complex_mac_lane
    import complex_dot_pkg::*;
#(
    parameter int ELEM_W = 64
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic                     i_conj,
    input  logic [ELEM_W-1:0]        i_a,
    input  logic [ELEM_W-1:0]        i_b,
    output logic signed [ELEM_W:0]   o_re,
    output logic signed [ELEM_W:0]   o_im
);
    localparam int H  = ELEM_W / 2;
    localparam int PW = ELEM_W + 1;

    logic signed [H-1:0]  w_ar, w_ai, w_br, w_bi;
    logic signed [PW-1:0] w_rr, w_ii, w_ri, w_ir;

    assign w_ar = i_en ? H'(cplx_re(MAX_ELEM_W'(i_a), ELEM_W)) : '0;
    assign w_ai = i_en ? H'(cplx_im(MAX_ELEM_W'(i_a), ELEM_W)) : '0;
    assign w_br = i_en ? H'(cplx_re(MAX_ELEM_W'(i_b), ELEM_W)) : '0;
    assign w_bi = i_en ? H'(cplx_im(MAX_ELEM_W'(i_b), ELEM_W)) : '0;

    // One extra bit keeps the two-product sum exact even at the most negative inputs.
    assign w_rr = PW'(w_ar) * PW'(w_br);
    assign w_ii = PW'(w_ai) * PW'(w_bi);
    assign w_ri = PW'(w_ar) * PW'(w_bi);
    assign w_ir = PW'(w_ai) * PW'(w_br);

    always_ff @(posedge i_clk) begin
        o_re <= i_conj ? w_rr + w_ii : w_rr - w_ii;
        o_im <= i_conj ? w_ir - w_ri : w_ri + w_ir;
    end

endmodule

// File: rtl/complex_dot_product_stream.sv
// complex_dot_product_stream: streaming (optionally Hermitian) complex inner product,
// LANES elements per beat, three-stage multiply / tree / accumulate pipeline with a held result.
module complex_dot_product_stream
    import complex_dot_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ELEM_W = 64,
    parameter int ACC_W  = ELEM_W + $clog2(LANES) + 17
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [31:0]               i_total,
    input  logic                      i_conj_b,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [LANES*ELEM_W-1:0]   i_vec_a,
    input  logic [LANES*ELEM_W-1:0]   i_vec_b,
    output logic                      o_busy,
    output logic                      o_out_valid,
    input  logic                      i_out_ack,
    output logic [ACC_W-1:0]          o_dot_real,
    output logic [ACC_W-1:0]          o_dot_imag
);
    localparam int LG = $clog2(LANES);

    state_t r_state, w_next;

    logic [31:0]              r_total, r_nbeats, r_beat, w_rem;
    logic                     r_conj;
    logic                     r_v1, r_v2, r_l1, r_l2;
    logic                     w_accept, w_last, w_start;
    logic signed [ELEM_W:0]   w_lane_re [LANES];
    logic signed [ELEM_W:0]   w_lane_im [LANES];
    logic signed [ACC_W-1:0]  w_tree_re, w_tree_im, r_sum_re, r_sum_im;
    logic signed [ACC_W-1:0]  r_acc_re, r_acc_im, r_dot_re, r_dot_im;

    assign w_start  = i_start & (r_state == IDLE);
    assign w_accept = i_in_valid & o_in_ready;
    assign w_last   = r_beat == r_nbeats - 32'd1;
    // Number of live lanes in the final beat.
    assign w_rem    = r_total - ((r_nbeats - 32'd1) << LG);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        complex_mac_lane #(.ELEM_W(ELEM_W)) u_lane (
            .i_clk  (i_clk),
            .i_en   (~w_last | (32'(i) < w_rem)),
            .i_conj (r_conj),
            .i_a    (i_vec_a[i*ELEM_W +: ELEM_W]),
            .i_b    (i_vec_b[i*ELEM_W +: ELEM_W]),
            .o_re   (w_lane_re[i]),
            .o_im   (w_lane_im[i])
        );
    end

    always_comb begin
        w_tree_re = '0;
        w_tree_im = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree_re = w_tree_re + ACC_W'(w_lane_re[i]);
            w_tree_im = w_tree_im + ACC_W'(w_lane_im[i]);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ((i_total == 32'd0) ? DONE : RUN) : IDLE;
            RUN:     w_next = (w_accept & w_last) ? DRAIN : RUN;
            DRAIN:   w_next = r_l2 ? DONE : DRAIN;
            DONE:    w_next = i_out_ack ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    assign o_in_ready  = r_state == RUN;
    assign o_busy      = r_state != IDLE;
    assign o_out_valid = r_state == DONE;
    assign o_dot_real  = r_dot_re;
    assign o_dot_imag  = r_dot_im;

    always_ff @(posedge i_clk) begin
        r_sum_re <= w_tree_re;
        r_sum_im <= w_tree_im;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_total  <= '0;
            r_nbeats <= '0;
            r_beat   <= '0;
            r_conj   <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_l1     <= 1'b0;
            r_l2     <= 1'b0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_dot_re <= '0;
            r_dot_im <= '0;
        end else begin
            r_state <= w_next;
            r_v1    <= w_accept;
            r_l1    <= w_accept & w_last;
            r_v2    <= r_v1;
            r_l2    <= r_l1;
            if (w_start) begin
                r_total  <= i_total;
                r_conj   <= i_conj_b;
                r_nbeats <= nbeats(i_total, LANES);
                r_beat   <= '0;
                r_acc_re <= '0;
                r_acc_im <= '0;
                if (i_total == 32'd0) begin
                    r_dot_re <= '0;
                    r_dot_im <= '0;
                end
            end else if (r_v2) begin
                r_acc_re <= r_acc_re + r_sum_re;
                r_acc_im <= r_acc_im + r_sum_im;
            end
            if (w_accept)
                r_beat <= r_beat + 32'd1;
            if (r_l2) begin
                r_dot_re <= r_acc_re + r_sum_re;
                r_dot_im <= r_acc_im + r_sum_im;
            end
        end
    end

endmodule

// File: tb/tb_complex_dot_product_stream.sv
// tb_complex_dot_product_stream: directed table of uniform-data jobs plus random-gap and reset/ack sequences.
module tb_complex_dot_product_stream;
    localparam int LANES = 8;
    localparam int EW    = 64;
    localparam int AW    = EW + 3 + 17;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_start = 1'b0;
    logic [31:0]       i_total = '0;
    logic              i_conj_b = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [LANES*EW-1:0] i_vec_a = '0;
    logic [LANES*EW-1:0] i_vec_b = '0;
    logic              o_busy;
    logic              o_out_valid;
    logic              i_out_ack = 1'b0;
    logic [AW-1:0]     o_dot_real, o_dot_imag;

    complex_dot_product_stream #(.LANES(LANES), .ELEM_W(EW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_total(i_total),
        .i_conj_b(i_conj_b), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_vec_a(i_vec_a), .i_vec_b(i_vec_b), .o_busy(o_busy), .o_out_valid(o_out_valid),
        .i_out_ack(i_out_ack), .o_dot_real(o_dot_real), .o_dot_imag(o_dot_imag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string              name;
        bit                 conj;
        int                 total;
        int                 ar, ai, br, bi;
        logic signed [AW-1:0] er, ei;
        int                 lat;
    } vec_t;

    vec_t                vecs [10];
    logic [LANES*EW-1:0] beat_a [64];
    logic [LANES*EW-1:0] beat_b [64];
    int                  n_pass = 0;
    int                  n_tot = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_uniform(input int ar, input int ai, input int br, input int bi);
        for (int k = 0; k < 64; k++)
            for (int l = 0; l < LANES; l++) begin
                beat_a[k][l*EW +: EW] = {32'(ar), 32'(ai)};
                beat_b[k][l*EW +: EW] = {32'(br), 32'(bi)};
            end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++)
            for (int l = 0; l < LANES; l++) begin
                beat_a[k][l*EW +: EW] = {$urandom, $urandom};
                beat_b[k][l*EW +: EW] = {$urandom, $urandom};
            end
    endtask

    task automatic golden(input bit conj, input int total,
                          output logic signed [AW-1:0] er, output logic signed [AW-1:0] ei);
        logic signed [31:0]   t;
        logic signed [AW-1:0] ar, ai, br, bi;
        er = '0;
        ei = '0;
        for (int idx = 0; idx < total; idx++) begin
            t = beat_a[idx/LANES][(idx%LANES)*EW+32 +: 32]; ar = t;
            t = beat_a[idx/LANES][(idx%LANES)*EW    +: 32]; ai = t;
            t = beat_b[idx/LANES][(idx%LANES)*EW+32 +: 32]; br = t;
            t = beat_b[idx/LANES][(idx%LANES)*EW    +: 32]; bi = t;
            er = er + (conj ? ar*br + ai*bi : ar*br - ai*bi);
            ei = ei + (conj ? ai*br - ar*bi : ar*bi + ai*br);
        end
    endtask

    // Starts a job, streams its beats, then counts edges from the last accepting edge to out_valid.
    task automatic run_job(input string name, input bit conj, input int total, input bit gaps, output int lat);
        int  nb, k, guard;
        bit  acc;
        nb = (total + LANES - 1) / LANES;
        k = 0;
        guard = 0;
        i_start = 1'b1;
        i_total = total;
        i_conj_b = conj;
        tick();
        i_start = 1'b0;
        i_total = 32'hdead_beef;
        i_conj_b = ~conj;
        while (k < nb && guard < 500) begin
            i_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_vec_a = beat_a[k];
            i_vec_b = beat_b[k];
            acc = i_in_valid && o_in_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        i_in_valid = 1'b1;
        i_vec_a = '1;
        i_vec_b = '1;
        lat = 1;
        guard = 0;
        while (!o_out_valid && guard < 200) begin
            tick();
            lat++;
            guard++;
        end
        i_in_valid = 1'b0;
        if (!o_out_valid) begin
            n_tot++;
            $display("FAIL %s_timeout: out_valid never rose, beats sent %0d of %0d", name, k, nb);
        end
    endtask

    task automatic ack(input string name);
        i_out_ack = 1'b1;
        tick();
        i_out_ack = 1'b0;
        chk({name, "_ack_ov"}, AW'(o_out_valid), '0);
        chk({name, "_ack_busy"}, AW'(o_busy), '0);
    endtask

    initial begin
        int lat;
        logic signed [AW-1:0] er, ei;
        vecs[0] = '{"plain",      0,  8, 1, 0, 2, 3, 16, 24, 3};
        vecs[1] = '{"conj",       1,  8, 1, 0, 2, 3, 16, -24, 3};
        vecs[2] = '{"jj_conj",    1,  8, 0, 1, 0, 1, 8, 0, 3};
        vecs[3] = '{"jj_plain",   0,  8, 0, 1, 0, 1, -8, 0, 3};
        vecs[4] = '{"mask_conj",  1, 13, 1, 1, 1, 1, 26, 0, 3};
        vecs[5] = '{"mask_plain", 0, 13, 1, 1, 1, 1, 0, 26, 3};
        vecs[6] = '{"one_elem",   0,  1, 3, -2, -4, 5, -2, 23, 3};
        vecs[7] = '{"two_full",   0, 16, -1, 0, -1, -1, 16, 16, 3};
        vecs[8] = '{"extreme",    0,  8, int'(32'h8000_0000), int'(32'h8000_0000),
                    int'(32'h8000_0000), int'(32'h8000_0000), 0, (AW'(1) << 66), 3};
        vecs[9] = '{"zero",       1,  0, 5, 5, 5, 5, 0, 0, 1};

        tick();
        tick();
        i_reset = 1'b0;
        chk("rst_in_ready", AW'(o_in_ready), '0);
        chk("rst_busy", AW'(o_busy), '0);
        chk("rst_out_valid", AW'(o_out_valid), '0);
        chk("rst_dot_re", o_dot_real, '0);
        chk("rst_dot_im", o_dot_imag, '0);

        for (int v = 0; v < 10; v++) begin
            fill_uniform(vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi);
            run_job(vecs[v].name, vecs[v].conj, vecs[v].total, 1'b0, lat);
            chk({vecs[v].name, "_lat"}, AW'(lat), AW'(vecs[v].lat));
            chk({vecs[v].name, "_re"}, o_dot_real, vecs[v].er);
            chk({vecs[v].name, "_im"}, o_dot_imag, vecs[v].ei);
            chk({vecs[v].name, "_rdy_done"}, AW'(o_in_ready), '0);
            ack(vecs[v].name);
        end

        fill_random();
        golden(1'b0, 32, er, ei);
        run_job("rand32", 1'b0, 32, 1'b1, lat);
        for (int c = 0; c < 10; c++) begin
            chk("rand32_re", o_dot_real, er);
            chk("rand32_im", o_dot_imag, ei);
            chk("rand32_hold", AW'(o_out_valid), AW'(1));
            tick();
        end
        ack("rand32");

        fill_random();
        golden(1'b1, 27, er, ei);
        run_job("rand27c", 1'b1, 27, 1'b1, lat);
        chk("rand27c_re", o_dot_real, er);
        chk("rand27c_im", o_dot_imag, ei);
        ack("rand27c");

        fill_uniform(5, 5, 5, 5);
        i_start = 1'b1;
        i_total = 16;
        i_conj_b = 1'b0;
        tick();
        i_start = 1'b0;
        i_in_valid = 1'b1;
        i_vec_a = beat_a[0];
        i_vec_b = beat_b[0];
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_in_valid = 1'b0;
        chk("abort_busy", AW'(o_busy), '0);
        chk("abort_dot", o_dot_real, '0);
        tick();
        tick();
        tick();
        chk("abort_idle_ov", AW'(o_out_valid), '0);
        fill_uniform(1, 0, 2, 3);
        run_job("after_rst", 1'b0, 8, 1'b0, lat);
        chk("after_rst_re", o_dot_real, AW'(16));
        chk("after_rst_im", o_dot_imag, AW'(24));

        i_start = 1'b1;
        i_total = 0;
        tick();
        i_start = 1'b0;
        chk("start_in_done_ov", AW'(o_out_valid), AW'(1));
        chk("start_in_done_re", o_dot_real, AW'(16));
        i_start = 1'b1;
        i_total = 8;
        i_out_ack = 1'b1;
        tick();
        i_start = 1'b0;
        i_out_ack = 1'b0;
        chk("ack_start_ov", AW'(o_out_valid), '0);
        chk("ack_start_busy", AW'(o_busy), '0);
        tick();
        chk("ack_start_still_idle", AW'(o_busy), '0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
